mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the I-cache and D-cache fill FSMs and the D-cache write-through path.
- Arbitrates the single pipelined main memory between these three requesters.
- Forwards the granted requester's address/command to memory.
- Steers returning read data valids only to the requester that owns the current fill. Late or orphaned returns are discarded.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, memory word width
MEM_LAT, 4, cycles from a read issue (mem_enable=1, mem_wr=0) to its mem_data_valid

Ports:
clk  in  1  clock
rst  in  1  reset
icache_busy  in  1  I-side fill FSM busy; acts as the fill request
icache_addr  in  ADDR_W  I-side fill chunk address
icache_data_valid  out  1  steered memory valid for I-side
icache_grant  out  1  I-side owns memory
dcache_busy  in  1  D-side fill FSM busy; acts as the fill request
dcache_addr  in  ADDR_W  D-side fill chunk address
dcache_data_valid  out  1  steered memory valid for D-side
dcache_grant  out  1  D-side owns memory
dwrite_req  in  1  write-through request; held until ack
dwrite_addr  in  ADDR_W  write address
dwrite_data  in  DATA_W  write data
dwrite_ack  out  1  one-cycle pulse when the write is issued
mem_enable  out  1  memory request
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  memory address
mem_data_in  out  DATA_W  memory write data
mem_data_out  in  DATA_W  memory read data
mem_data_valid  in  1  memory read data valid
fill_data  out  DATA_W  mem_data_out broadcast to both caches

Behaviour:
- Interface decided: single clock clk; rst is asynchronous, active-high. On assertion, state, in-flight pipe and all outputs go to 0 / IDLE immediately.
- States: IDLE, IFILL, DFILL, DWRITE, DRAIN.
- IDLE, fixed priority evaluated each cycle:
  - dcache_busy -> DFILL.
  - else dwrite_req -> DWRITE.
  - else icache_busy -> IFILL.
  - No memory outputs asserted in IDLE.
- IFILL / DFILL:
  - Outputs: grant=1; mem_enable=1; mem_wr=0; mem_addr = owner addr (combinational, same cycle).
  - A read is issued every cycle, including repeats of the same chunk.
  - When owner busy=0: if no reads are in flight -> IDLE, else -> DRAIN. mem_enable=0 in that cycle.
- DRAIN:
  - No grant, no issue.
  - All returns are discarded.
  - -> IDLE when the in-flight count reaches 0.
- DWRITE:
  - Lasts exactly one cycle: mem_enable=1, mem_wr=1, mem_addr=dwrite_addr, mem_data_in=dwrite_data, dwrite_ack=1.
  - -> IDLE next cycle. Requester drops dwrite_req after ack.
- In-flight tracking:
  - A MEM_LAT-deep shift pipe records {issued, owner} each cycle.
  - The head of the pipe aligns with mem_data_valid.
- Steering:
  - x_data_valid = mem_data_valid & head.issued & head.owner==x & state==x's FILL in the arrival cycle.
  - Otherwise the return is discarded.
  - mem_data_valid with head.issued=0 is ignored.
- fill_data = mem_data_out, unconditionally.
- A non-granted fill FSM receives no valids and therefore waits. No extra stall signal is needed.
- Simultaneous events:
  - Owner busy falling in the same cycle as a matching return: the return is still delivered.
  - Requests arriving in DRAIN/DWRITE wait for IDLE.
  - Grant is never preempted mid-fill.
- mem_wr, mem_data_in, mem_addr are 0 whenever mem_enable=0.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum;
  - owner encoding (OWN_NONE, OWN_I, OWN_D);
  - MEM_LAT default.
- Sub-module mem_tag_pipe: MEM_LAT-stage {issued, owner} shift register with an in-flight counter. It provides head outputs and an empty flag, and is cleared by rst.

Test Plan:
1. I-fill alone:
   - Stimulus: icache_busy=1 at cycle 0, memory returns a valid every cycle from cycle 1+MEM_LAT.
   - Response: icache_grant=1 from cycle 1; mem_addr==icache_addr each cycle.
   - Response: after busy drops, DRAIN discards 3 trailing returns (icache_data_valid=0), then IDLE.
2. Contention:
   - Stimulus: icache_busy and dcache_busy both rise at cycle 0.
   - Response: dcache_grant=1 and icache_data_valid stays 0 throughout the D fill.
   - Response: after DRAIN empties, icache_grant=1.
3. Write alone:
   - Stimulus: dwrite_req=1, addr 0x1234, data 0xBEEF at cycle 0.
   - Response: cycle 1: mem_enable=1, mem_wr=1, mem_addr=0x1234, mem_data_in=0xBEEF, dwrite_ack=1.
   - Response: cycle 2: IDLE with all outputs 0.
4. Write during I-fill:
   - Stimulus: dwrite_req raised mid-IFILL.
   - Response: no ack until after IFILL→DRAIN→IDLE.
   - Response: the write then wins over a pending icache_busy; exactly one ack pulse.
5. Orphan return:
   - Stimulus: mem_data_valid=1 while IDLE with an empty pipe.
   - Response: both data_valids stay 0.
6. Reset mid-DFILL:
   - Stimulus: rst pulse during cycle 5 of a D-fill.
   - Response: grants, mem_enable and valids drop to 0 asynchronously.
   - Response: returns arriving after release are ignored; the block is in IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory arbiter: arbiter states, fill ownership
// and the per-cycle read tag that travels alongside the memory pipeline.
package mem_arb_pkg;

    localparam int MEM_LAT_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IFILL,
        ST_DFILL,
        ST_DWRITE,
        ST_DRAIN
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    typedef struct packed {
        logic   issued;
        owner_t owner;
    } tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the three requester channels plus the main-memory port.
// The arbiter uses the slave view; caches and memory drive the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();

    logic              icache_busy;
    logic [ADDR_W-1:0] icache_addr;
    logic              icache_data_valid;
    logic              icache_grant;

    logic              dcache_busy;
    logic [ADDR_W-1:0] dcache_addr;
    logic              dcache_data_valid;
    logic              dcache_grant;

    logic              dwrite_req;
    logic [ADDR_W-1:0] dwrite_addr;
    logic [DATA_W-1:0] dwrite_data;
    logic              dwrite_ack;

    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_valid;
    logic [DATA_W-1:0] fill_data;

    modport slave (
        input  icache_busy, icache_addr, dcache_busy, dcache_addr,
               dwrite_req, dwrite_addr, dwrite_data, mem_data_out, mem_data_valid,
        output icache_data_valid, icache_grant, dcache_data_valid, dcache_grant,
               dwrite_ack, mem_enable, mem_wr, mem_addr, mem_data_in, fill_data
    );

    modport master (
        output icache_busy, icache_addr, dcache_busy, dcache_addr,
               dwrite_req, dwrite_addr, dwrite_data, mem_data_out, mem_data_valid,
        input  icache_data_valid, icache_grant, dcache_data_valid, dcache_grant,
               dwrite_ack, mem_enable, mem_wr, mem_addr, mem_data_in, fill_data
    );

endinterface

// File: rtl/mem_tag_pipe.sv
// Shift pipe of {issued, owner} tags matching the memory read latency, so the
// head tag lines up with mem_data_valid; also counts reads still in flight.
module mem_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = MEM_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  tag_t push,
    output tag_t head,
    output logic empty
);

    localparam int CW = $clog2(DEPTH + 1);

    tag_t          stages [DEPTH];
    logic [CW-1:0] count;

    // Count rises on every issued push and falls as an issued tag leaves the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
            count <= '0;
        end else begin
            stages[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
            count <= count + CW'(push.issued) - CW'(stages[DEPTH-1].issued);
        end
    end

    assign head  = stages[DEPTH-1];
    assign empty = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one pipelined memory between the I-fill,
// D-fill and D-write-through paths, steering read valids to the fill owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_t state, state_next;
    tag_t       push, head;
    logic       pipe_empty;

    mem_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .head  (head),
        .empty (pipe_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A fill keeps its grant until its busy drops; leftover reads are then drained.
    always_comb begin
        state_next            = state;
        push                  = '{issued: 1'b0, owner: OWN_NONE};
        bus.icache_grant      = 1'b0;
        bus.dcache_grant      = 1'b0;
        bus.dwrite_ack        = 1'b0;
        bus.mem_enable        = 1'b0;
        bus.mem_wr            = 1'b0;
        bus.mem_addr          = {ADDR_W{1'b0}};
        bus.mem_data_in       = {DATA_W{1'b0}};
        case (state)
            ST_IDLE: begin
                if (bus.dcache_busy) begin
                    state_next = ST_DFILL;
                end else if (bus.dwrite_req) begin
                    state_next = ST_DWRITE;
                end else if (bus.icache_busy) begin
                    state_next = ST_IFILL;
                end
            end
            ST_IFILL: begin
                bus.icache_grant = 1'b1;
                if (bus.icache_busy) begin
                    bus.mem_enable = 1'b1;
                    bus.mem_addr   = bus.icache_addr;
                    push           = '{issued: 1'b1, owner: OWN_I};
                end else begin
                    state_next = pipe_empty ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DFILL: begin
                bus.dcache_grant = 1'b1;
                if (bus.dcache_busy) begin
                    bus.mem_enable = 1'b1;
                    bus.mem_addr   = bus.dcache_addr;
                    push           = '{issued: 1'b1, owner: OWN_D};
                end else begin
                    state_next = pipe_empty ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DWRITE: begin
                bus.mem_enable  = 1'b1;
                bus.mem_wr      = 1'b1;
                bus.mem_addr    = bus.dwrite_addr;
                bus.mem_data_in = bus.dwrite_data;
                bus.dwrite_ack  = 1'b1;
                state_next      = ST_IDLE;
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.icache_data_valid = bus.mem_data_valid & head.issued &
                                   (head.owner == OWN_I) & (state == ST_IFILL);
    assign bus.dcache_data_valid = bus.mem_data_valid & head.issued &
                                   (head.owner == OWN_D) & (state == ST_DFILL);
    assign bus.fill_data         = bus.mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// all compared against a cycle-level reference model built on an issue log.
module tb_mem_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int MEM_LAT = 4;

    localparam int M_IDLE  = 0;
    localparam int M_IFILL = 1;
    localparam int M_DFILL = 2;
    localparam int M_WRITE = 3;
    localparam int M_DRAIN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: arbitration mode plus a log of (issue cycle, owner) reads.
    int mode       = M_IDLE;
    int cycleNum   = 0;
    int issueCycle [$];
    int issueWho   [$];
    int ackCount   = 0;
    bit lastAck    = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cycleNum);
        end
    endtask

    task automatic modelReset();
        mode = M_IDLE;
        issueCycle.delete();
        issueWho.delete();
    endtask

    task automatic applyStimulus(input logic ib, input logic db, input logic wr, input logic mv);
        bus.icache_busy    = ib;
        bus.dcache_busy    = db;
        bus.dwrite_req     = wr;
        bus.mem_data_valid = mv;
        bus.icache_addr    = ADDR_W'($urandom);
        bus.dcache_addr    = ADDR_W'($urandom);
        bus.mem_data_out   = DATA_W'($urandom);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_igrant"}, 32'(bus.icache_grant), 0);
        checkOutput({tag, "_dgrant"}, 32'(bus.dcache_grant), 0);
        checkOutput({tag, "_en"},     32'(bus.mem_enable), 0);
        checkOutput({tag, "_ivalid"}, 32'(bus.icache_data_valid), 0);
        checkOutput({tag, "_dvalid"}, 32'(bus.dcache_data_valid), 0);
        checkOutput({tag, "_ack"},    32'(bus.dwrite_ack), 0);
    endtask

    // One clock: predict and compare at the falling edge, then advance the model.
    task automatic runCycle();
        int   inflight;
        bit   due;
        int   dueWho;
        bit   issue;
        int   who;
        logic eIg, eDg, eIv, eDv, eAck, eEn, eWr;
        logic [ADDR_W-1:0] eAddr;
        logic [DATA_W-1:0] eData;
        @(negedge clk);
        if (rst) begin
            checkIdleOutputs("rst");
            modelReset();
            lastAck = 1'b0;
        end else begin
            while (issueCycle.size() > 0 && issueCycle[0] < cycleNum - MEM_LAT) begin
                void'(issueCycle.pop_front());
                void'(issueWho.pop_front());
            end
            inflight = issueCycle.size();
            due      = (inflight > 0) && (issueCycle[0] == cycleNum - MEM_LAT);
            dueWho   = due ? issueWho[0] : 0;
            {eIg, eDg, eAck, eEn, eWr} = '0;
            eAddr = '0;
            eData = '0;
            issue = 1'b0;
            who   = 0;
            case (mode)
                M_IFILL: begin
                    eIg = 1'b1;
                    if (bus.icache_busy) begin
                        eEn = 1'b1; eAddr = bus.icache_addr; issue = 1'b1; who = 1;
                    end
                end
                M_DFILL: begin
                    eDg = 1'b1;
                    if (bus.dcache_busy) begin
                        eEn = 1'b1; eAddr = bus.dcache_addr; issue = 1'b1; who = 2;
                    end
                end
                M_WRITE: begin
                    eEn = 1'b1; eWr = 1'b1; eAck = 1'b1;
                    eAddr = bus.dwrite_addr; eData = bus.dwrite_data;
                end
                default: ;
            endcase
            eIv = bus.mem_data_valid && due && dueWho == 1 && mode == M_IFILL;
            eDv = bus.mem_data_valid && due && dueWho == 2 && mode == M_DFILL;
            checkOutput("igrant",  32'(bus.icache_grant), 32'(eIg));
            checkOutput("dgrant",  32'(bus.dcache_grant), 32'(eDg));
            checkOutput("ivalid",  32'(bus.icache_data_valid), 32'(eIv));
            checkOutput("dvalid",  32'(bus.dcache_data_valid), 32'(eDv));
            checkOutput("ack",     32'(bus.dwrite_ack), 32'(eAck));
            checkOutput("en",      32'(bus.mem_enable), 32'(eEn));
            checkOutput("wr",      32'(bus.mem_wr), 32'(eWr));
            checkOutput("addr",    32'(bus.mem_addr), 32'(eAddr));
            checkOutput("wdata",   32'(bus.mem_data_in), 32'(eData));
            checkOutput("filldat", 32'(bus.fill_data), 32'(bus.mem_data_out));
            lastAck  = eAck;
            ackCount = ackCount + int'(eAck);
            case (mode)
                M_IDLE: begin
                    if (bus.dcache_busy)      mode = M_DFILL;
                    else if (bus.dwrite_req)  mode = M_WRITE;
                    else if (bus.icache_busy) mode = M_IFILL;
                end
                M_IFILL: if (!bus.icache_busy) mode = (inflight == 0) ? M_IDLE : M_DRAIN;
                M_DFILL: if (!bus.dcache_busy) mode = (inflight == 0) ? M_IDLE : M_DRAIN;
                M_WRITE: mode = M_IDLE;
                M_DRAIN: if (inflight == 0) mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
            if (issue) begin
                issueCycle.push_back(cycleNum);
                issueWho.push_back(who);
            end
        end
        cycleNum++;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle; the write requester drops its request once acknowledged.
    task automatic stepWith(input logic ib, input logic db, input logic wr, input logic mv);
        applyStimulus(ib, db, wr, mv);
        runCycle();
        if (lastAck) bus.dwrite_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acksBefore;
        logic ib, db, wr;
        bus.dwrite_addr = '0;
        bus.dwrite_data = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        runCycle();
        runCycle();
        rst = 1'b0;

        $display("[TB] scenario 1: I-fill alone");
        for (int i = 0; i < 12; i++) stepWith(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)  stepWith(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] scenario 2: contention");
        for (int i = 0; i < 10; i++) stepWith(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) stepWith(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("contend_igrant", 32'(bus.icache_grant), 1);
        for (int i = 0; i < 8; i++)  stepWith(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] scenario 3: write alone");
        bus.dwrite_addr = 16'h1234;
        bus.dwrite_data = 16'hBEEF;
        acksBefore = ackCount;
        stepWith(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) stepWith(1'b0, 1'b0, bus.dwrite_req, 1'b0);
        checkOutput("write_acks", 32'(ackCount - acksBefore), 1);

        $display("[TB] scenario 4: write during I-fill");
        for (int i = 0; i < 3; i++) stepWith(1'b1, 1'b0, 1'b0, 1'b1);
        bus.dwrite_addr = 16'h0A5A;
        bus.dwrite_data = 16'h5A5A;
        acksBefore = ackCount;
        for (int i = 0; i < 5; i++) stepWith(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("wr_midfill_noack", 32'(ackCount - acksBefore), 0);
        stepWith(1'b0, 1'b0, bus.dwrite_req, 1'b1);
        for (int i = 0; i < 12; i++) stepWith(1'b1, 1'b0, bus.dwrite_req, 1'b1);
        checkOutput("wr_midfill_acks", 32'(ackCount - acksBefore), 1);
        for (int i = 0; i < 8; i++) stepWith(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] scenario 5: orphan return");
        for (int i = 0; i < 6; i++) stepWith(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] scenario 6: reset mid D-fill");
        for (int i = 0; i < 6; i++) stepWith(1'b0, 1'b1, 1'b0, 1'b1);
        #3;
        rst = 1'b1;
        bus.dcache_busy = 1'b0;
        #1;
        checkIdleOutputs("async_rst");
        runCycle();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) stepWith(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] scenario 7: random traffic");
        ib = 1'b0; db = 1'b0; wr = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!ib) ib = ($urandom_range(0, 7) == 0); else ib = ($urandom_range(0, 9) != 0);
            if (!db) db = ($urandom_range(0, 9) == 0); else db = ($urandom_range(0, 7) != 0);
            wr = bus.dwrite_req;
            if (!wr && $urandom_range(0, 15) == 0) begin
                wr = 1'b1;
                bus.dwrite_addr = ADDR_W'($urandom);
                bus.dwrite_data = DATA_W'($urandom);
            end
            stepWith(ib, db, wr, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
